// File: rtl/alu_pkg.sv
// Opcode encoding, sequencer state enum and opcode classification helpers
// shared by the ALU operation sequencer and its bench.
package alu_pkg;

   localparam logic [4:0] OP_LD   = 5'b00000;
   localparam logic [4:0] OP_LDI  = 5'b00001;
   localparam logic [4:0] OP_ST   = 5'b00010;
   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_AND  = 5'b00101;
   localparam logic [4:0] OP_OR   = 5'b00110;
   localparam logic [4:0] OP_ROR  = 5'b00111;
   localparam logic [4:0] OP_ROL  = 5'b01000;
   localparam logic [4:0] OP_SHR  = 5'b01001;
   localparam logic [4:0] OP_SHRA = 5'b01010;
   localparam logic [4:0] OP_SHL  = 5'b01011;
   localparam logic [4:0] OP_ADDI = 5'b01100;
   localparam logic [4:0] OP_ANDI = 5'b01101;
   localparam logic [4:0] OP_ORI  = 5'b01110;
   localparam logic [4:0] OP_DIV  = 5'b01111;
   localparam logic [4:0] OP_MUL  = 5'b10000;
   localparam logic [4:0] OP_NEG  = 5'b10001;
   localparam logic [4:0] OP_NOT  = 5'b10010;
   localparam logic [4:0] OP_BR   = 5'b10011;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD_Y,
      ST_EXEC,
      ST_WAIT,
      ST_WB_LO,
      ST_WB_HI
   } state_t;

   function automatic logic is_muldiv(input logic [4:0] op);
      return (op == OP_MUL) || (op == OP_DIV);
   endfunction

   // Everything above OP_BR (5'b10100..5'b11111) is unsupported.
   function automatic logic is_legal(input logic [4:0] op);
      return op <= OP_BR;
   endfunction

endpackage

// File: rtl/alu_wait_counter.sv
// Purpose: 4-bit loadable down-counter timing the mul/div wait; zero flag ends the wait.
// Latency: load/decrement take effect on the next clock; zero is combinational from the count.
// Backpressure: none; decrement is ignored once the count reaches zero.
module alu_wait_counter (
   input  logic       clock,
   input  logic       clear_n,
   input  logic       load,
   input  logic [3:0] load_val,
   input  logic       dec,
   output logic       zero
);

   logic [3:0] count;

   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         count <= 4'd0;
      end else if (load) begin
         count <= load_val;
      end else if (dec && !zero) begin
         count <= count - 4'd1;
      end
   end

   assign zero = (count == 4'd0);

endmodule

// File: rtl/alu_op_sequencer.sv
// Purpose: sequences Y load, execute, Z capture and writeback for one ALU op; ALU_SEQ_DIVZERO_EN adds divide-by-zero abort.
// Latency: single-result op done at T+3, mul/div at T+4+MULDIV_LAT, unsupported opcode at T+1.
// Backpressure: req_ready only in IDLE and not during a done pulse; requests while busy are dropped.
module alu_op_sequencer
   import alu_pkg::*;
#(
   parameter int MULDIV_LAT = 4
) (
   input  logic       clock,
   input  logic       clear_n,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [4:0] req_opcode,
   input  logic       req_divisor_zero,
   output logic [4:0] alu_opcode,
   output logic       y_in,
   output logic       z_in,
   output logic       z_low_out,
   output logic       z_high_out,
   output logic       rz_in,
   output logic       lo_in,
   output logic       hi_in,
   output logic       busy,
   output logic       done,
   output logic       bad_op,
   output logic       err_divzero
);

   state_t state_q, state_d;
   logic   bad_q;
   logic   xfer;
   logic   md;
   logic   div_abort;
   logic   cnt_zero;

   assign xfer = req_valid && req_ready;
   assign md   = is_muldiv(alu_opcode);

`ifdef ALU_SEQ_DIVZERO_EN
   logic dz_q;

   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         dz_q <= 1'b0;
      end else if (xfer && is_legal(req_opcode)) begin
         dz_q <= req_divisor_zero;
      end
   end

   assign div_abort = dz_q && (alu_opcode == OP_DIV);
`else
   logic unused_divisor_zero;

   assign unused_divisor_zero = req_divisor_zero;
   assign div_abort           = 1'b0;
`endif

   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         state_q    <= ST_IDLE;
         alu_opcode <= 5'b00000;
         bad_q      <= 1'b0;
      end else begin
         state_q <= state_d;
         // An unsupported opcode never reaches the datapath; only its done/bad_op pulse is remembered.
         bad_q   <= xfer && !is_legal(req_opcode);
         if (xfer && is_legal(req_opcode)) begin
            alu_opcode <= req_opcode;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (xfer && is_legal(req_opcode)) state_d = ST_LOAD_Y;
         ST_LOAD_Y: state_d = ST_EXEC;
         ST_EXEC: begin
            if (div_abort)  state_d = ST_IDLE;
            else if (md)    state_d = ST_WAIT;
            else            state_d = ST_WB_LO;
         end
         ST_WAIT:   if (cnt_zero) state_d = ST_WB_LO;
         ST_WB_LO:  state_d = md ? ST_WB_HI : ST_IDLE;
         ST_WB_HI:  state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      y_in        = 1'b0;
      z_in        = 1'b0;
      z_low_out   = 1'b0;
      z_high_out  = 1'b0;
      rz_in       = 1'b0;
      lo_in       = 1'b0;
      hi_in       = 1'b0;
      done        = 1'b0;
      bad_op      = 1'b0;
      err_divzero = 1'b0;
      case (state_q)
         ST_LOAD_Y: y_in = 1'b1;
         ST_EXEC: begin
            if (div_abort) begin
               done        = 1'b1;
               err_divzero = 1'b1;
            end else if (!md) begin
               z_in = 1'b1;
            end
         end
         ST_WAIT:   z_in = cnt_zero;
         ST_WB_LO: begin
            z_low_out = 1'b1;
            if (md) begin
               lo_in = 1'b1;
            end else begin
               rz_in = 1'b1;
               done  = 1'b1;
            end
         end
         ST_WB_HI: begin
            z_high_out = 1'b1;
            hi_in      = 1'b1;
            done       = 1'b1;
         end
         default: ;
      endcase
      if (bad_q) begin
         done   = 1'b1;
         bad_op = 1'b1;
      end
   end

   assign busy      = (state_q != ST_IDLE);
   assign req_ready = (state_q == ST_IDLE) && !bad_q;

   // Loaded with MULDIV_LAT-1 in EXEC so z_in lands exactly MULDIV_LAT cycles after execute starts.
   alu_wait_counter u_wait_counter (
      .clock    (clock),
      .clear_n  (clear_n),
      .load     ((state_q == ST_EXEC) && md && !div_abort),
      .load_val (4'(MULDIV_LAT - 1)),
      .dec      (state_q == ST_WAIT),
      .zero     (cnt_zero)
   );

endmodule
